// File: rtl/csr_apb_pkg.sv
// Shared types and constants for the ExampleCsr APB access block.
//   apb_state_e  : responder FSM state encoding
//   DATA_W       : register / bus data width
//   ACTRL_ADDR   : default byte address of ACTRL
//   BCTRL_ADDR   : default byte address of BCTRL
package csr_apb_pkg;

  localparam int         DATA_W     = 32;
  localparam logic [7:0] ACTRL_ADDR = 8'h00;
  localparam logic [7:0] BCTRL_ADDR = 8'h04;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_state_e;

endpackage

// File: rtl/csr_addr_decode.sv
// Combinational address decode for the ExampleCsr register block.
// Ports:
//   paddr      in   byte address of the current transfer
//   hit_actrl  out  address selects ACTRL
//   hit_bctrl  out  address selects BCTRL
//   err        out  misaligned or unmapped address
module csr_addr_decode
  import csr_apb_pkg::*;
#(
  parameter int                ADDR_W       = 8,
  parameter logic [ADDR_W-1:0] ACTRL_OFFSET = ADDR_W'(ACTRL_ADDR),
  parameter logic [ADDR_W-1:0] BCTRL_OFFSET = ADDR_W'(BCTRL_ADDR)
) (
  input  logic [ADDR_W-1:0] paddr,
  output logic              hit_actrl,
  output logic              hit_bctrl,
  output logic              err
);

  logic aligned;

  // Only the word index is compared; the byte lane bits only gate alignment.
  assign aligned   = (paddr[1:0] == 2'b00);
  assign hit_actrl = aligned && (paddr[ADDR_W-1:2] == ACTRL_OFFSET[ADDR_W-1:2]);
  assign hit_bctrl = aligned && (paddr[ADDR_W-1:2] == BCTRL_OFFSET[ADDR_W-1:2]);
  assign err       = !(hit_actrl || hit_bctrl);

endmodule

// File: rtl/csr_apb_access.sv
// APB3/APB4 responder for the ExampleCsr register block. Turns APB transfers
// into per-register byte write strobes, a BCTRL read side-effect pulse and a
// shared write-data bus; returns register contents on prdata.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   psel, penable, pwrite           APB control
//   paddr, pwdata, pstrb            APB address / write data / byte strobes
//   pready, prdata, pslverr         registered APB response
//   reg_wdata                       write data to the register block
//   actrl_byte_we, bctrl_byte_we    byte write enables, 1-cycle pulse
//   bctrl_read_en                   BCTRL read side-effect pulse
//   actrl_reg, bctrl_reg            current register values
//
// state | meaning
// IDLE  | waiting for an APB setup phase
// WAIT  | counting down inserted wait states, abort if psel drops
// RESP  | pready high for one cycle, strobes/read data presented
module csr_apb_access
  import csr_apb_pkg::*;
#(
  parameter int                ADDR_W       = 8,
  parameter int                WAIT_CYCLES  = 0,
  parameter logic [ADDR_W-1:0] ACTRL_OFFSET = ADDR_W'(ACTRL_ADDR),
  parameter logic [ADDR_W-1:0] BCTRL_OFFSET = ADDR_W'(BCTRL_ADDR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [3:0]        pstrb,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic [3:0]        actrl_byte_we,
  output logic [3:0]        bctrl_byte_we,
  output logic              bctrl_read_en,
  input  logic [DATA_W-1:0] actrl_reg,
  input  logic [DATA_W-1:0] bctrl_reg
);

  apb_state_e        state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        strb_q;

  logic              setup;
  logic              enter_resp;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_write;
  logic [DATA_W-1:0] cur_wdata;
  logic [3:0]        cur_strb;
  logic              hit_actrl, hit_bctrl, err;

  assign setup = psel && !penable;

  // With no wait states the transfer goes straight from IDLE to RESP, so the
  // response is built from the live bus; after WAIT it uses the latched copy.
  assign cur_addr  = (state == IDLE) ? paddr  : addr_q;
  assign cur_write = (state == IDLE) ? pwrite : write_q;
  assign cur_wdata = (state == IDLE) ? pwdata : wdata_q;
  assign cur_strb  = (state == IDLE) ? pstrb  : strb_q;

  csr_addr_decode #(
    .ADDR_W      (ADDR_W),
    .ACTRL_OFFSET(ACTRL_OFFSET),
    .BCTRL_OFFSET(BCTRL_OFFSET)
  ) u_decode (
    .paddr    (cur_addr),
    .hit_actrl(hit_actrl),
    .hit_bctrl(hit_bctrl),
    .err      (err)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (setup) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == 4'd0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RESP always returns to IDLE, so this is high for one cycle per transfer
  // and strobes can never repeat on consecutive cycles.
  assign enter_resp = (state_nxt == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && setup) begin
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
        strb_q  <= pstrb;
      end
    end
  end

  // Read data is captured on the edge into RESP, before bctrl_read_en lets
  // the register block apply any clear-on-read side effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pready        <= 1'b0;
      pslverr       <= 1'b0;
      prdata        <= '0;
      reg_wdata     <= '0;
      actrl_byte_we <= '0;
      bctrl_byte_we <= '0;
      bctrl_read_en <= 1'b0;
    end else begin
      pready        <= enter_resp;
      pslverr       <= enter_resp && err;
      prdata        <= '0;
      actrl_byte_we <= '0;
      bctrl_byte_we <= '0;
      bctrl_read_en <= 1'b0;
      if (enter_resp && !err) begin
        if (cur_write) begin
          reg_wdata <= cur_wdata;
          if (hit_actrl) actrl_byte_we <= cur_strb;
          if (hit_bctrl) bctrl_byte_we <= cur_strb;
        end else begin
          prdata        <= hit_actrl ? actrl_reg : bctrl_reg;
          bctrl_read_en <= hit_bctrl;
        end
      end
    end
  end

endmodule

// File: tb/tb_csr_apb_access.sv
// Self-checking bench for csr_apb_access. Three instances with 0, 3 and 4
// wait states share the bus; a small register block model closes the loop
// from the byte strobes back to actrl_reg/bctrl_reg.
`timescale 1ns/1ps
module tb_csr_apb_access;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [ND-1:0]       psel;
  logic                penable, pwrite;
  logic [7:0]          paddr;
  logic [31:0]         pwdata;
  logic [3:0]          pstrb;
  logic [ND-1:0]       pready, pslverr, bctrl_read_en;
  logic [ND-1:0][31:0] prdata, reg_wdata, actrl_q, bctrl_q;
  logic [ND-1:0][3:0]  actrl_we, bctrl_we;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    csr_apb_access #(
      .ADDR_W     (8),
      .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .psel         (psel[g]),
      .penable      (penable),
      .pwrite       (pwrite),
      .paddr        (paddr),
      .pwdata       (pwdata),
      .pstrb        (pstrb),
      .pready       (pready[g]),
      .prdata       (prdata[g]),
      .pslverr      (pslverr[g]),
      .reg_wdata    (reg_wdata[g]),
      .actrl_byte_we(actrl_we[g]),
      .bctrl_byte_we(bctrl_we[g]),
      .bctrl_read_en(bctrl_read_en[g]),
      .actrl_reg    (actrl_q[g]),
      .bctrl_reg    (bctrl_q[g])
    );
  end

  // Register block stand-in: applies byte strobes from reg_wdata.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      actrl_q <= '0;
      bctrl_q <= '0;
    end else begin
      for (int d = 0; d < ND; d++)
        for (int b = 0; b < 4; b++) begin
          if (actrl_we[d][b]) actrl_q[d][8*b +: 8] <= reg_wdata[d][8*b +: 8];
          if (bctrl_we[d][b]) bctrl_q[d][8*b +: 8] <= reg_wdata[d][8*b +: 8];
        end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [31:0] shadow [ND][2];

  typedef struct {
    int          lat;
    int          cyc;
    int          stray;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  awe, bwe;
    logic        ren;
    logic [31:0] wdata;
  } obs_t;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  awe, bwe;
    logic        ren;
  } exp_t;

  typedef struct {
    logic [7:0]  addr;
    logic        wr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  awe, bwe;
    logic        ren;
  } vec_t;

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: word 0 is ACTRL, word 1 is BCTRL, anything else or a
  // misaligned address is an error. Writes merge bytes into the shadow.
  task automatic model(input int d, input logic [7:0] addr, input logic wr,
                       input logic [31:0] data, input logic [3:0] strb, output exp_t e);
    int word;
    word    = int'(addr) / 4;
    e.lat   = 1 + wait_of(d);
    e.err   = (int'(addr) % 4 != 0) || (word > 1);
    e.rdata = '0;
    e.awe   = '0;
    e.bwe   = '0;
    e.ren   = 1'b0;
    if (!e.err) begin
      if (wr) begin
        if (word == 0) e.awe = strb; else e.bwe = strb;
        for (int b = 0; b < 4; b++)
          if (strb[b]) shadow[d][word][8*b +: 8] = data[8*b +: 8];
      end else begin
        e.rdata = shadow[d][word];
        e.ren   = (word == 1);
      end
    end
  endtask

  task automatic xfer(input int d, input logic [7:0] addr, input logic wr,
                      input logic [31:0] data, input logic [3:0] strb, output obs_t o);
    @(negedge clk);
    chk("idle_pready", 32'(pready[d]), 32'd0);
    chk("idle_strobes", 32'({actrl_we[d], bctrl_we[d], bctrl_read_en[d]}), 32'd0);
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    @(negedge clk);
    penable = 1'b1;
    o.lat   = 1;
    o.stray = 0;
    while (!pready[d] && o.lat < 40) begin
      if (actrl_we[d] != 0 || bctrl_we[d] != 0 || bctrl_read_en[d] || pslverr[d] || prdata[d] != 0)
        o.stray++;
      @(negedge clk);
      o.lat++;
    end
    o.cyc   = cyc;
    o.err   = pslverr[d];
    o.rdata = prdata[d];
    o.awe   = actrl_we[d];
    o.bwe   = bctrl_we[d];
    o.ren   = bctrl_read_en[d];
    o.wdata = reg_wdata[d];
    // Bus noise during RESP must be ignored.
    paddr  = 8'($urandom);
    pwrite = ~wr;
  endtask

  task automatic compare(input string tag, input exp_t e, input obs_t o,
                         input logic wr, input logic [31:0] data);
    chk({tag, "_latency"}, 32'(o.lat), 32'(e.lat));
    chk({tag, "_pslverr"}, 32'(o.err), 32'(e.err));
    if (!wr || e.err) chk({tag, "_prdata"}, o.rdata, e.rdata);
    chk({tag, "_actrl_we"}, 32'(o.awe), 32'(e.awe));
    chk({tag, "_bctrl_we"}, 32'(o.bwe), 32'(e.bwe));
    chk({tag, "_read_en"}, 32'(o.ren), 32'(e.ren));
    chk({tag, "_early_activity"}, 32'(o.stray), 32'd0);
    if (wr && !e.err) chk({tag, "_reg_wdata"}, o.wdata, data);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      psel    = '0;
      penable = 1'b0;
    end
  endtask

  task automatic clear_shadow();
    for (int d = 0; d < ND; d++) begin
      shadow[d][0] = '0;
      shadow[d][1] = '0;
    end
  endtask

  function automatic logic [31:0] all_outs();
    logic [31:0] acc;
    acc = '0;
    for (int d = 0; d < ND; d++)
      acc |= prdata[d] | 32'({pready[d], pslverr[d], bctrl_read_en[d], actrl_we[d], bctrl_we[d]});
    return acc;
  endfunction

  vec_t tbl [12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    obs_t o;
    exp_t e;
    exp_t dummy;
    int   prev_cyc;
    int   stray;

    tbl[0]  = '{8'h00, 1'b1, 32'hA5A5_1234, 4'b0101, 1'b0, 32'h0,          4'b0101, 4'h0, 1'b0};
    tbl[1]  = '{8'h00, 1'b0, 32'h0,         4'hF,    1'b0, 32'h00A5_0034,  4'h0,    4'h0, 1'b0};
    tbl[2]  = '{8'h04, 1'b1, 32'hDEAD_BEEF, 4'hF,    1'b0, 32'h0,          4'h0,    4'hF, 1'b0};
    tbl[3]  = '{8'h04, 1'b0, 32'h0,         4'hF,    1'b0, 32'hDEAD_BEEF,  4'h0,    4'h0, 1'b1};
    tbl[4]  = '{8'h08, 1'b1, 32'h1234_5678, 4'hF,    1'b1, 32'h0,          4'h0,    4'h0, 1'b0};
    tbl[5]  = '{8'h02, 1'b0, 32'h0,         4'hF,    1'b1, 32'h0,          4'h0,    4'h0, 1'b0};
    tbl[6]  = '{8'h00, 1'b1, 32'hFFFF_FFFF, 4'h0,    1'b0, 32'h0,          4'h0,    4'h0, 1'b0};
    tbl[7]  = '{8'h00, 1'b0, 32'h0,         4'hF,    1'b0, 32'h00A5_0034,  4'h0,    4'h0, 1'b0};
    tbl[8]  = '{8'h00, 1'b1, 32'h1122_3344, 4'b1010, 1'b0, 32'h0,          4'b1010, 4'h0, 1'b0};
    tbl[9]  = '{8'h00, 1'b0, 32'h0,         4'hF,    1'b0, 32'h11A5_3334,  4'h0,    4'h0, 1'b0};
    tbl[10] = '{8'hFC, 1'b0, 32'h0,         4'hF,    1'b1, 32'h0,          4'h0,    4'h0, 1'b0};
    tbl[11] = '{8'h05, 1'b1, 32'hFFFF_0000, 4'hF,    1'b1, 32'h0,          4'h0,    4'h0, 1'b0};

    clear_shadow();
    rst_n = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 32'd0);
    rst_n = 1'b1;

    // Table on the zero-wait instance, all back-to-back.
    prev_cyc = 0;
    for (int i = 0; i < 12; i++) begin
      model(0, tbl[i].addr, tbl[i].wr, tbl[i].data, tbl[i].strb, dummy);
      e.lat = 1; e.err = tbl[i].err; e.rdata = tbl[i].rdata;
      e.awe = tbl[i].awe; e.bwe = tbl[i].bwe; e.ren = tbl[i].ren;
      xfer(0, tbl[i].addr, tbl[i].wr, tbl[i].data, tbl[i].strb, o);
      compare($sformatf("tbl%0d", i), e, o, tbl[i].wr, tbl[i].data);
      if (i > 0) chk($sformatf("tbl%0d_b2b_spacing", i), 32'(o.cyc - prev_cyc), 32'd2);
      prev_cyc = o.cyc;
    end
    idle(2);

    // Three wait states: BCTRL write then read.
    model(1, 8'h04, 1'b1, 32'hDEAD_BEEF, 4'hF, e);
    xfer(1, 8'h04, 1'b1, 32'hDEAD_BEEF, 4'hF, o);
    compare("w3_write_bctrl", e, o, 1'b1, 32'hDEAD_BEEF);
    model(1, 8'h04, 1'b0, 32'h0, 4'hF, e);
    xfer(1, 8'h04, 1'b0, 32'h0, 4'hF, o);
    compare("w3_read_bctrl", e, o, 1'b0, 32'h0);
    idle(2);

    // Abort on the four-wait instance after two access cycles.
    model(2, 8'h00, 1'b1, 32'h0BAD_F00D, 4'hF, e);
    xfer(2, 8'h00, 1'b1, 32'h0BAD_F00D, 4'hF, o);
    compare("w4_write_actrl", e, o, 1'b1, 32'h0BAD_F00D);
    @(negedge clk);
    psel = '0; psel[2] = 1'b1; penable = 1'b0;
    pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
    @(negedge clk); penable = 1'b1;
    @(negedge clk);
    psel = '0; penable = 1'b0;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (pready[2] || actrl_we[2] != 0 || bctrl_we[2] != 0 || bctrl_read_en[2]) stray++;
    end
    chk("abort_no_response", 32'(stray), 32'd0);
    model(2, 8'h00, 1'b0, 32'h0, 4'hF, e);
    xfer(2, 8'h00, 1'b0, 32'h0, 4'hF, o);
    compare("abort_then_read", e, o, 1'b0, 32'h0);
    idle(2);

    // Reset while a read response is on the bus.
    @(negedge clk);
    psel = '0; psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h04;
    @(negedge clk); penable = 1'b1;
    chk("pre_reset_pready", 32'(pready[0]), 32'd1);
    chk("pre_reset_prdata", prdata[0], shadow[0][1]);
    rst_n = 1'b0;
    #1;
    chk("reset_in_resp_outputs", all_outs(), 32'd0);
    psel = '0; penable = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    clear_shadow();

    // Reset during the wait states of a write.
    @(negedge clk);
    psel = '0; psel[1] = 1'b1; penable = 1'b0;
    pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h5555_AAAA; pstrb = 4'hF;
    @(negedge clk); penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_in_wait_outputs", all_outs(), 32'd0);
    psel = '0; penable = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model(1, 8'h00, 1'b0, 32'h0, 4'hF, e);
    xfer(1, 8'h00, 1'b0, 32'h0, 4'hF, o);
    compare("post_reset_read", e, o, 1'b0, 32'h0);

    // Random traffic against the reference model.
    for (int n = 0; n < 200; n++) begin
      int          d;
      logic [7:0]  a;
      logic        w;
      logic [31:0] dat;
      logic [3:0]  s;
      d = $urandom_range(0, ND - 1);
      case ($urandom_range(0, 5))
        0:       a = 8'h00;
        1:       a = 8'h04;
        2:       a = 8'($urandom);
        3:       a = 8'($urandom_range(1, 3)) | (($urandom_range(0, 1) != 0) ? 8'h04 : 8'h00);
        4:       a = 8'h08;
        default: a = ($urandom_range(0, 1) != 0) ? 8'h04 : 8'h00;
      endcase
      w   = 1'($urandom_range(0, 1));
      dat = $urandom;
      s   = 4'($urandom);
      model(d, a, w, dat, s, e);
      xfer(d, a, w, dat, s, o);
      compare($sformatf("rnd%0d", n), e, o, w, dat);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
